// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: scoreboards in-flight register writes, raises
// pipe_stop on RAW/WAW/occupancy hazards and sequences inst_clear after redirects.
module hazard_ctrl #(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_rd_wen,
  input  logic              id_fire,
  input  logic              wb_wen,
  input  logic [4:0]        wb_rd,
  input  logic              redirect_valid,
  output logic              pipe_stop,
  output logic              inst_clear,
  output logic [31:0]       busy_mask,
  output logic [PERF_W-1:0] stall_count,
  output logic [PERF_W-1:0] flush_count
);

  localparam int unsigned NREG   = 32;
  localparam int unsigned PEND_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PEND_W-1:0]   pend_q [NREG];
  logic [PEND_W-1:0]   pend_d [NREG];
  logic [PEND_W-1:0]   inflight_q, inflight_d;
  logic [NREG-1:0]     busy_q;
  logic                inst_clear_q;
  logic [PERF_W-1:0]   stall_q, flush_q;

  logic inc_any, dec_any;
  logic raw, waw, full, hazard;

  assign inc_any = id_fire & id_rd_wen & (id_rd != 5'd0);
  assign dec_any = wb_wen & (wb_rd != 5'd0);

  // Per-register pending-write counters; a same-register issue and retire cancel out.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
    end
    for (int unsigned r = 1; r < NREG; r++) begin
      if (inc_any && (id_rd == 5'(r)) && !(dec_any && (wb_rd == 5'(r)))) begin
        if (pend_q[r] != PEND_W'(DEPTH)) begin
          pend_d[r] = pend_q[r] + PEND_W'(1);
        end
      end else if (dec_any && (wb_rd == 5'(r)) && !(inc_any && (id_rd == 5'(r)))) begin
        if (pend_q[r] != '0) begin
          pend_d[r] = pend_q[r] - PEND_W'(1);
        end
      end
    end
  end

  // Occupancy between ID issue and WB retire.
  always_comb begin
    inflight_d = inflight_q;
    if (id_fire && !wb_wen) begin
      inflight_d = inflight_q + PEND_W'(1);
    end else if (wb_wen && !id_fire && (inflight_q != '0)) begin
      inflight_d = inflight_q - PEND_W'(1);
    end
  end

  // Hazard detection is purely on registered scoreboard state: no WB bypass.
  assign raw = id_valid &
               ((id_rs1_used & (id_rs1 != 5'd0) & (pend_q[id_rs1] != '0)) |
                (id_rs2_used & (id_rs2 != 5'd0) & (pend_q[id_rs2] != '0)));
  assign waw    = id_valid & id_rd_wen & (id_rd != 5'd0) & (pend_q[id_rd] == PEND_W'(DEPTH));
  assign full   = id_valid & (inflight_q == PEND_W'(DEPTH));
  assign hazard = raw | waw | full;

  // A redirect (or an active flush) overrides any stall.
  assign pipe_stop = hazard & (state_q != ST_FLUSH) & ~redirect_valid;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end else if (hazard) begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (redirect_valid) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end else if (!hazard) begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (redirect_valid) begin
          cnt_d = CNT_W'(FLUSH_CYCLES);
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      inflight_q   <= '0;
      busy_q       <= '0;
      inst_clear_q <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      inst_clear_q <= (state_d == ST_FLUSH);
      stall_q      <= stall_q + PERF_W'(pipe_stop);
      flush_q      <= flush_q + PERF_W'(redirect_valid);
      for (int unsigned r = 0; r < NREG; r++) begin
        pend_q[r] <= pend_d[r];
        busy_q[r] <= (pend_d[r] != '0);
      end
    end
  end

  assign inst_clear  = inst_clear_q;
  assign busy_mask   = busy_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

  // Issuing into a stalled decode stage is an IDU protocol violation.
  assert property (@(posedge clock) disable iff (!reset) !(id_fire && pipe_stop));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// each cycle checked against an abstract model of pending writes and flush timing.
module tb_hazard_ctrl;

  localparam int unsigned DEPTH        = 3;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned PERF_W       = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              id_valid, id_rs1_used, id_rs2_used, id_rd_wen, id_fire;
  logic [4:0]        id_rs1, id_rs2, id_rd, wb_rd;
  logic              wb_wen, redirect_valid;
  logic              pipe_stop, inst_clear;
  logic [31:0]       busy_mask;
  logic [PERF_W-1:0] stall_count, flush_count;

  always #5 clock = ~clock;

  hazard_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .PERF_W(PERF_W)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_fire(id_fire),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .redirect_valid(redirect_valid),
    .pipe_stop(pipe_stop), .inst_clear(inst_clear), .busy_mask(busy_mask),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct {
    logic        ps;
    logic        ic;
    logic [31:0] bm;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: pending-write counts, occupancy, remaining flush cycles.
  int          pend[32];
  int          inflight;
  int          flush_left;
  logic [31:0] m_stall, m_flush;
  int          fifo[$];   // rd of each in-flight instruction, 32 = no write

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pipe_stop",   32'(pipe_stop),   32'(e.ps));
        chk("inst_clear",  32'(inst_clear),  32'(e.ic));
        chk("busy_mask",   busy_mask,        e.bm);
        chk("stall_count", stall_count,      e.sc);
        chk("flush_count", flush_count,      e.fc);
      end
    end
  end

  function automatic bit model_hazard(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                                      input bit u1, input bit u2, input logic [4:0] rd,
                                      input bit wen);
    bit raw, waw, full;
    raw  = v && ((u1 && r1 != 0 && pend[r1] > 0) || (u2 && r2 != 0 && pend[r2] > 0));
    waw  = v && wen && rd != 0 && pend[rd] == DEPTH;
    full = v && inflight == DEPTH;
    return raw || waw || full;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    inflight   = 0;
    flush_left = 0;
    m_stall    = '0;
    m_flush    = '0;
    fifo.delete();
  endtask

  // One clock: drive inputs, queue expected outputs, advance the model past the edge.
  task automatic cycle(input bit rst_n, input bit v, input logic [4:0] r1, input logic [4:0] r2,
                       input bit u1, input bit u2, input logic [4:0] rd, input bit wen,
                       input bit want_fire, input bit want_wb, input bit redir);
    bit hz, fire, wbw, rdv, inc, dec;
    logic [4:0] wbrd;
    exp_t e;
    hz   = model_hazard(v, r1, r2, u1, u2, rd, wen);
    fire = rst_n && want_fire && v && !hz;
    wbw  = rst_n && want_wb && (fifo.size() > 0);
    rdv  = rst_n && redir;
    wbrd = 5'd0;
    if (wbw) wbrd = (fifo[0] < 32) ? 5'(fifo[0]) : 5'($urandom_range(0, 31));

    reset = rst_n; id_valid = v; id_rs1 = r1; id_rs2 = r2;
    id_rs1_used = u1; id_rs2_used = u2; id_rd = rd; id_rd_wen = wen;
    id_fire = fire; wb_wen = wbw; wb_rd = wbrd; redirect_valid = rdv;

    e.ps = hz && (flush_left == 0) && !rdv;
    e.ic = (flush_left > 0);
    e.bm = '0;
    for (int i = 1; i < 32; i++) e.bm[i] = (pend[i] > 0);
    e.sc = m_stall;
    e.fc = m_flush;
    expq.push_back(e);

    @(posedge clock);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      inc = fire && wen && rd != 0;
      dec = wbw && wbrd != 0;
      if (!(inc && dec && rd == wbrd)) begin
        if (inc) pend[rd]++;
        if (dec && pend[wbrd] > 0) pend[wbrd]--;
      end
      if (fire && !wbw) inflight++;
      else if (wbw && !fire && inflight > 0) inflight--;
      if (wbw) void'(fifo.pop_front());
      if (fire) fifo.push_back(wen ? int'(rd) : 32);
      if (rdv) flush_left = FLUSH_CYCLES;
      else if (flush_left > 0) flush_left--;
      m_stall += 32'(e.ps);
      m_flush += 32'(rdv);
    end
  endtask

  task automatic idle(input bit wb);
    cycle(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, wb, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) idle(1'b1);
  endtask

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
    id_rs2_used = 1'b0; id_rd = '0; id_rd_wen = 1'b0; id_fire = 1'b0;
    wb_wen = 1'b0; wb_rd = '0; redirect_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    idle(1'b0);

    // RAW on x5: issue, stall while pending, WB in stall cycle still stalls.
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0);
    cycle(1, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 1, 0, 0);
    cycle(1, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 1, 0, 0);
    cycle(1, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 1, 1, 0);
    cycle(1, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 1, 0, 0);
    drain();

    // x0 writes are never tracked.
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0);
    cycle(1, 1, 5'd0, 5'd0, 1, 1, 5'd3, 0, 1, 0, 0);
    drain();

    // Occupancy limit: three in flight, fourth stalls until one retires.
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd1, 1, 1, 0, 0);
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd2, 1, 1, 0, 0);
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd3, 0, 1, 0, 0);
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0, 0);
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 1, 0);
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd4, 1, 1, 0, 0);
    drain();

    // Redirect during stall, then a second redirect inside the flush window.
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0, 0);
    cycle(1, 1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
    cycle(1, 1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1);
    cycle(1, 1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
    cycle(1, 1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 5'd9, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
    drain();

    // Same-cycle issue and retire of x7 leaves its count unchanged.
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 0, 0);
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 1, 0);
    idle(1'b0);
    drain();

    // Reset during flush with x5/x6 pending.
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0);
    cycle(1, 1, 5'd0, 5'd0, 0, 0, 5'd6, 1, 1, 0, 1);
    cycle(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    idle(1'b0);

    // Random traffic on a small register window to provoke frequent hazards.
    for (int n = 0; n < 3000; n++) begin
      bit rst_n;
      rst_n = ($urandom_range(0, 199) != 0);
      if (!rst_n)
        cycle(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
      else
        cycle(1'b1, ($urandom_range(0, 4) != 0),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4),
              ($urandom_range(0, 15) == 0));
    end

    repeat (2) @(negedge clock);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending expectations required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
